key_exp_seq: RTL and testbench

Iterative AES key-schedule engine covering AES-128, AES-192 and AES-256, selected per run by a mode input.
- Generates one 32-bit round-key word per cycle onto a valid/ready stream, indices 0..Nw-1.
- Uses a shared SubWord unit (4 S-box lookups) and a sliding window of the last Nk words, so it needs no full-schedule storage.
- Sits between the key-load logic and the round pipeline. It is the sequential, multi-length successor to the single-length combinational expander.

---
 rtl/key_exp_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_key_exp_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/key_exp_seq.sv
// Iterative AES-128/192/256 key schedule: one round-key word per handshake from a sliding Nk-word window.
// Optional macro KEY_EXP_SEQ_RDPORT_EN adds a 60-word schedule store with a registered read port.
module key_exp_seq #(
    parameter int MAX_NK = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [255:0]      key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [5:0]        out_idx,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef KEY_EXP_SEQ_RDPORT_EN
    ,
    input  logic [5:0]        rd_addr,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid
`endif
);

    if (WORD_W != 32) begin : g_word_w_check
        $error("key_exp_seq: WORD_W must be 32");
    end
    if (MAX_NK != 4 && MAX_NK != 6 && MAX_NK != 8) begin : g_max_nk_check
        $error("key_exp_seq: MAX_NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, KEYOUT, EXPAND, FIN} state_t;

    state_t            state, state_nxt;
    logic [3:0]        nk;
    logic [5:0]        nw;
    logic [2:0]        phase, phase_nxt;
    logic [7:0]        rcon, rcon_nxt;
    logic [WORD_W-1:0] win [MAX_NK];
    logic [WORD_W-1:0] win_nxt [MAX_NK];
    logic [WORD_W-1:0] t, p, w_new, key_nxt;
    logic [3:0]        nk_sel;
    logic [5:0]        nw_sel;
    logic              legal, fire, last_key, last_word;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0), followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [WORD_W-1:0] sub_word(input logic [WORD_W-1:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [WORD_W-1:0] key_word(input logic [255:0] k, input int j);
        return k[255 - 32*j -: WORD_W];
    endfunction

    always_comb begin
        nk_sel = 4'd0;
        nw_sel = 6'd0;
        case (mode)
            2'd0:    begin nk_sel = 4'd4; nw_sel = 6'd44; end
            2'd1:    begin nk_sel = 4'd6; nw_sel = 6'd52; end
            2'd2:    begin nk_sel = 4'd8; nw_sel = 6'd60; end
            default: begin nk_sel = 4'd0; nw_sel = 6'd0;  end
        endcase
        legal = (mode != 2'd3) && (int'(nk_sel) <= MAX_NK);
    end

    assign fire      = out_valid && out_ready;
    assign last_key  = (out_idx == {2'b00, nk} - 6'd1);
    assign last_word = (out_idx == nw - 6'd1);

    // Window view at the handshake: in EXPAND the word being accepted is shifted in first.
    always_comb begin
        for (int j = 0; j < MAX_NK; j++) win_nxt[j] = win[j];
        if (state == EXPAND) begin
            for (int j = 0; j < MAX_NK - 1; j++) win_nxt[j] = win[j + 1];
            win_nxt[MAX_NK-1] = out_word;
        end
        t       = win_nxt[MAX_NK-1];
        p       = '0;
        key_nxt = '0;
        for (int j = 0; j < MAX_NK; j++) begin
            if (j == MAX_NK - int'(nk)) p = win_nxt[j];
            if (j == MAX_NK - int'(nk) + int'(out_idx) + 1) key_nxt = win[j];
        end
        if (phase == 3'd0)
            w_new = sub_word(rot_word(t)) ^ {rcon, 24'h000000} ^ p;
        else if (nk == 4'd8 && phase == 3'd4)
            w_new = sub_word(t) ^ p;
        else
            w_new = t ^ p;
        phase_nxt = ({1'b0, phase} == nk - 4'd1) ? 3'd0 : phase + 3'd1;
        rcon_nxt  = (phase == 3'd0) ? xtime(rcon) : rcon;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && legal)    state_nxt = KEYOUT;
            KEYOUT:  if (fire && last_key)  state_nxt = EXPAND;
            EXPAND:  if (fire && last_word) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nk        <= 4'd0;
            nw        <= 6'd0;
            phase     <= 3'd0;
            rcon      <= 8'h00;
            out_idx   <= 6'd0;
            out_word  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int j = 0; j < MAX_NK; j++) win[j] <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && legal) begin
                        nk        <= nk_sel;
                        nw        <= nw_sel;
                        rcon      <= 8'h01;
                        phase     <= 3'd0;
                        out_idx   <= 6'd0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_word  <= key_word(key, 0);
                        for (int j = 0; j < MAX_NK; j++) begin
                            if (j >= MAX_NK - int'(nk_sel))
                                win[j] <= key_word(key, j - (MAX_NK - int'(nk_sel)));
                            else
                                win[j] <= '0;
                        end
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                KEYOUT: begin
                    if (fire) begin
                        out_idx <= out_idx + 6'd1;
                        if (last_key) begin
                            out_word <= w_new;
                            phase    <= phase_nxt;
                            rcon     <= rcon_nxt;
                        end else begin
                            out_word <= key_nxt;
                        end
                    end
                end
                EXPAND: begin
                    if (fire) begin
                        for (int j = 0; j < MAX_NK; j++) win[j] <= win_nxt[j];
                        if (last_word) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx  <= out_idx + 6'd1;
                            out_word <= w_new;
                            phase    <= phase_nxt;
                            rcon     <= rcon_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KEY_EXP_SEQ_RDPORT_EN
    logic [WORD_W-1:0] store [60];
    logic [59:0]       written;

    // Store writes and reads carry no reset; the written mask decides what is visible.
    always_ff @(posedge clk) begin
        if (fire && busy) store[out_idx] <= out_word;
        if (rd_addr < nw && written[rd_addr]) rd_data <= store[rd_addr];
        else                                  rd_data <= '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written  <= '0;
            rd_valid <= 1'b0;
        end else if (state == IDLE && start && legal) begin
            written  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (fire && busy) written[out_idx] <= 1'b1;
            if (done)         rd_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_key_exp_seq.sv
// Randomized bench for key_exp_seq against a table-driven FIPS-197 key-schedule model.
module tb_key_exp_seq;
    logic         clk = 1'b0;
    logic         reset, start, out_ready;
    logic [1:0]   mode;
    logic [255:0] key;
    logic         out_valid, busy, done, err;
    logic [31:0]  out_word;
    logic [5:0]   out_idx;
`ifdef KEY_EXP_SEQ_RDPORT_EN
    logic [5:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         rd_valid;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  sbox_t [256];
    logic [31:0] ref_w  [60];
    logic [31:0] got_w  [60];
    int          ref_nw;

    localparam logic [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always #5 clk = ~clk;

    key_exp_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mode      (mode),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
`ifdef KEY_EXP_SEQ_RDPORT_EN
        ,
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry-less product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_prod(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] prod;
        prod = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) prod = prod ^ (15'(a) << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--)
            if (prod[bit_i]) prod = prod ^ (15'h11b << (bit_i - 8));
        return prod[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_prod(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic gen_ref(input logic [1:0] m, input logic [255:0] k);
        int nk;
        logic [31:0] tmp;
        nk = (m == 2'd0) ? 4 : (m == 2'd1) ? 6 : 8;
        ref_nw = 4 * nk + 28;
        for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < ref_nw; i++) begin
            tmp = ref_w[i-1];
            if (i % nk == 0)
                tmp = sub({tmp[23:0], tmp[31:24]}) ^ {RC[i/nk - 1], 24'h0};
            else if (nk == 8 && i % nk == 4)
                tmp = sub(tmp);
            ref_w[i] = ref_w[i-nk] ^ tmp;
        end
    endtask

    task automatic run(input logic [1:0] m, input logic [255:0] k, input int stall_pct,
                       input int abort_at, input bit poke_start);
        int e, cyc;
        bit stalled, nostall;
        logic [31:0] held_w;
        logic [5:0]  held_i;
        gen_ref(m, k);
        mode = m; key = k; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'($urandom);
        key   = {8{$urandom}};
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_idx", 64'(out_idx), 64'd0);
        e = 0; cyc = 1; stalled = 0; nostall = (stall_pct == 0);
        held_w = '0; held_i = '0;
        while (e < ref_nw && cyc < 3000) begin
            if (abort_at >= 0 && e == abort_at && out_valid) begin
                reset = 1'b1;
                @(negedge clk);
                check("abort_outs", 64'({out_valid, busy, done, err, out_word, out_idx}), 64'd0);
                reset = 1'b0;
                @(negedge clk);
                check("abort_no_done", 64'({done, busy, out_valid}), 64'd0);
                return;
            end
            out_ready = ($urandom_range(99) >= stall_pct);
            if (poke_start) start = (e == 10);
            if (stalled) begin
                check($sformatf("stall_word%0d", e), 64'(out_word), 64'(held_w));
                check($sformatf("stall_idx%0d", e), 64'(out_idx), 64'(held_i));
            end
            if (out_valid) begin
                check($sformatf("idx%0d", e), 64'(out_idx), 64'(e));
                check($sformatf("word%0d", e), 64'(out_word), 64'(ref_w[e]));
                check($sformatf("busy%0d", e), 64'(busy), 64'd1);
                got_w[e] = out_word;
                if (nostall && e == ref_nw - 1) check("last_cycle", 64'(cyc), 64'(ref_nw));
                if (out_ready) e++;
            end
            stalled = out_valid && !out_ready;
            held_w  = out_word;
            held_i  = out_idx;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        if (e < ref_nw) check("timeout_words", 64'(e), 64'(ref_nw));
        check("done_pulse", 64'({done, busy, out_valid}), 64'b100);
        if (nostall) check("done_cycle", 64'(cyc), 64'(ref_nw + 1));
        @(negedge clk);
        check("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        logic [255:0] rk;
        reset = 1'b1; start = 1'b0; mode = 2'd0; key = '0; out_ready = 1'b0;
`ifdef KEY_EXP_SEQ_RDPORT_EN
        rd_addr = 6'd0;
`endif
        build_sbox();
        @(negedge clk);
        @(negedge clk);
        check("reset_outs", 64'({out_valid, busy, done, err, out_word, out_idx}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run(2'd0, K128, 0, -1, 1'b0);
        check("aes128_w4", 64'(got_w[4]), 64'h a0fafe17);
        check("aes128_w43", 64'(got_w[43]), 64'h b6630ca6);

        run(2'd1, K192, 0, -1, 1'b1);
        check("aes192_w6", 64'(got_w[6]), 64'h fe0c91f7);
        check("aes192_w51", 64'(got_w[51]), 64'h 01002202);

        run(2'd2, K256, 30, -1, 1'b0);
        check("aes256_w8", 64'(got_w[8]), 64'h 9ba35411);
        check("aes256_w12", 64'(got_w[12]), 64'h a8b09c1a);
        check("aes256_w59", 64'(got_w[59]), 64'h 706c631e);

        mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_pulse", 64'({err, busy, out_valid}), 64'b100);
        @(negedge clk);
        check("err_clear", 64'({err, busy, out_valid}), 64'b000);

        run(2'd0, K128, 0, 20, 1'b0);
        run(2'd2, K256, 0, -1, 1'b0);
        check("restart_w59", 64'(got_w[59]), 64'h 706c631e);
`ifdef KEY_EXP_SEQ_RDPORT_EN
        check("rd_valid", 64'(rd_valid), 64'd1);
        rd_addr = 6'd59;
        @(negedge clk);
        check("rd_w59", 64'(rd_data), 64'h 706c631e);
        rd_addr = 6'd60;
        @(negedge clk);
        check("rd_oob", 64'(rd_data), 64'd0);
`endif

        for (int r = 0; r < 4; r++) begin
            for (int q = 0; q < 8; q++) rk[32*q +: 32] = $urandom;
            run(2'($urandom_range(2)), rk, 25, -1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
